oflow_core_fsm_fe: RTL and testbench

Feature-extraction sequencer for the oflow core. It walks the bbox sets of a frame and pulses start_fe_i to the active PEs for each set. It gathers the per-PE done_fe_i, then hands each finished set to the registration FSM by pulsing done_fe. FE of set k+1 may overlap registration of set k, but done_fe for set k+1 is held until registration has acknowledged set k with done_registration. The block sits directly upstream of the registration FSM, and the core top FSM drives it.

---
 rtl/oflow_core_fsm_fe.sv | 136 +++++++++++++
 tb/tb_oflow_core_fsm_fe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_core_fsm_fe.sv
// Feature-extraction sequencer for the oflow core.
// Walks the bbox sets of a frame, launches the active PEs for each set, collects
// their done flags and hands each finished set to the registration FSM. FE of
// the next set overlaps registration of the previous one; the next done_fe is
// held until the previous set has been acknowledged with done_registration.
module oflow_core_fsm_fe #(
    parameter int unsigned PE_NUM          = 24,
    parameter int unsigned SET_LEN         = 9,
    parameter int unsigned REMAIN_BBOX_LEN = 5
) (
    input  logic                       clk,
    input  logic                       reset_N,
    input  logic                       start_fe,
    input  logic [SET_LEN-1:0]         num_of_sets,
    input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
    input  logic [PE_NUM-1:0]          done_fe_i,
    input  logic                       done_registration,
    output logic [PE_NUM-1:0]          start_fe_i,
    output logic                       done_fe,
    output logic [SET_LEN-1:0]         counter_set_fe,
    output logic                       busy,
    output logic                       frame_done
);

    typedef enum logic [2:0] {
        idle_st  = 3'd0,
        fe_st    = 3'd1,
        wait_st  = 3'd2,
        hold_st  = 3'd3,
        drain_st = 3'd4,
        done_st  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [SET_LEN-1:0]   counter_set_fe_q, counter_set_fe_d;
    logic [PE_NUM-1:0]    done_mask_q, done_mask_d;
    logic                 reg_pending_q, reg_pending_d;

    logic                 last_set;
    logic [PE_NUM-1:0]    active_mask;
    int unsigned          remain_n;

    // Only the last set may be partially populated; 0 remaining means a full set.
    always_comb begin
        last_set = (counter_set_fe_q == (num_of_sets - SET_LEN'(1)));
        remain_n = 32'(counter_of_remain_bboxes);
        if (remain_n == 0) begin
            remain_n = PE_NUM;
        end
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            active_mask[i] = last_set ? (i < remain_n) : 1'b1;
        end
    end

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state_q          <= idle_st;
            counter_set_fe_q <= '0;
            done_mask_q      <= '0;
            reg_pending_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            counter_set_fe_q <= counter_set_fe_d;
            done_mask_q      <= done_mask_d;
            reg_pending_q    <= reg_pending_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        counter_set_fe_d = counter_set_fe_q;
        done_mask_d      = done_mask_q;
        reg_pending_d    = reg_pending_q;
        start_fe_i       = '0;
        done_fe          = 1'b0;
        frame_done       = 1'b0;

        // Acknowledge from registration clears the pending flag; a release in
        // hold_st below overrides it so a coincident set/clear leaves it set.
        if ((state_q != idle_st) && done_registration) begin
            reg_pending_d = 1'b0;
        end

        unique case (state_q)
            idle_st: begin
                if (start_fe) begin
                    counter_set_fe_d = '0;
                    state_d          = (num_of_sets != '0) ? fe_st : done_st;
                end
            end
            fe_st: begin
                start_fe_i  = active_mask;
                done_mask_d = '0;
                state_d     = wait_st;
            end
            wait_st: begin
                done_mask_d = done_mask_q | (done_fe_i & active_mask);
                if (((done_mask_q | done_fe_i) & active_mask) == active_mask) begin
                    state_d = hold_st;
                end
            end
            hold_st: begin
                if (!reg_pending_q || done_registration) begin
                    done_fe       = 1'b1;
                    reg_pending_d = 1'b1;
                    if (last_set) begin
                        state_d = drain_st;
                    end else begin
                        counter_set_fe_d = counter_set_fe_q + SET_LEN'(1);
                        state_d          = fe_st;
                    end
                end
            end
            drain_st: begin
                if (done_registration) begin
                    reg_pending_d = 1'b0;
                    state_d       = done_st;
                end
            end
            done_st: begin
                frame_done       = 1'b1;
                counter_set_fe_d = '0;
                state_d          = idle_st;
            end
            default: begin
                state_d = idle_st;
            end
        endcase
    end

    assign busy           = (state_q != idle_st);
    assign counter_set_fe = counter_set_fe_q;

endmodule

// File: tb/tb_oflow_core_fsm_fe.sv
// Directed bench for oflow_core_fsm_fe: drives whole frames with a per-PE done
// schedule, records pulse cycles relative to start_fe and compares them with
// hand-computed timelines.
module tb_oflow_core_fsm_fe;

    localparam int unsigned PE_NUM          = 24;
    localparam int unsigned SET_LEN         = 9;
    localparam int unsigned REMAIN_BBOX_LEN = 5;

    logic                       clk;
    logic                       reset_N;
    logic                       start_fe;
    logic [SET_LEN-1:0]         num_of_sets;
    logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes;
    logic [PE_NUM-1:0]          done_fe_i;
    logic                       done_registration;
    logic [PE_NUM-1:0]          start_fe_i;
    logic                       done_fe;
    logic [SET_LEN-1:0]         counter_set_fe;
    logic                       busy;
    logic                       frame_done;

    int n_checks;
    int n_pass;

    // Per-PE done delay (cycles after its start_fe_i pulse).
    int pe_delay [PE_NUM];

    // Event record of the last frame run.
    int                 n_st, n_df, n_fd, fd_cyc;
    int                 st_cyc [8];
    logic [PE_NUM-1:0]  st_val [8];
    logic [SET_LEN-1:0] st_cnt [8];
    int                 df_cyc [8];
    logic               busy_at [64];

    oflow_core_fsm_fe #(
        .PE_NUM          (PE_NUM),
        .SET_LEN         (SET_LEN),
        .REMAIN_BBOX_LEN (REMAIN_BBOX_LEN)
    ) dut (
        .clk                      (clk),
        .reset_N                  (reset_N),
        .start_fe                 (start_fe),
        .num_of_sets              (num_of_sets),
        .counter_of_remain_bboxes (counter_of_remain_bboxes),
        .done_fe_i                (done_fe_i),
        .done_registration        (done_registration),
        .start_fe_i               (start_fe_i),
        .done_fe                  (done_fe),
        .counter_set_fe           (counter_set_fe),
        .busy                     (busy),
        .frame_done               (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < int'(PE_NUM); i++) pe_delay[i] = d;
    endtask

    // Runs one frame: start_fe at cycle 0, then max_cyc observed cycles.
    // done_registration follows each done_fe by reg_delay cycles.
    task automatic run_frame(input int nsets, input int remain, input int reg_delay,
                             input int max_cyc, input int stale_c, input int repulse_c);
        int last_start;
        int reg_due;
        n_st = 0; n_df = 0; n_fd = 0; fd_cyc = -1;
        last_start = -1000;
        reg_due    = -1;
        for (int k = 0; k < 64; k++) busy_at[k] = 1'bx;
        start_fe                 = 1'b1;
        num_of_sets              = SET_LEN'(nsets);
        counter_of_remain_bboxes = REMAIN_BBOX_LEN'(remain);
        done_fe_i                = '0;
        done_registration        = 1'b0;
        step();
        for (int c = 1; c <= max_cyc; c++) begin
            start_fe = (c == repulse_c);
            for (int i = 0; i < int'(PE_NUM); i++) begin
                done_fe_i[i] = ((c - last_start) == pe_delay[i]) || (c == stale_c);
            end
            done_registration = (c == reg_due);
            #1;
            if (c < 64) busy_at[c] = busy;
            if (start_fe_i != '0 && n_st < 8) begin
                st_cyc[n_st] = c;
                st_val[n_st] = start_fe_i;
                st_cnt[n_st] = counter_set_fe;
                n_st++;
                last_start = c;
            end
            if (done_fe && n_df < 8) begin
                df_cyc[n_df] = c;
                n_df++;
                reg_due = c + reg_delay;
            end
            if (frame_done) begin
                fd_cyc = c;
                n_fd++;
            end
            step();
        end
        start_fe          = 1'b0;
        done_fe_i         = '0;
        done_registration = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_start_fe_i"}, 32'(start_fe_i), 32'h0);
        check({tag, "_done_fe"}, 32'(done_fe), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        check({tag, "_counter"}, 32'(counter_set_fe), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_N                  = 1'b0;
        start_fe                 = 1'b0;
        num_of_sets              = '0;
        counter_of_remain_bboxes = '0;
        done_fe_i                = '0;
        done_registration        = 1'b0;
        step();
        step();
        check_outputs_zero("rst");
        reset_N = 1'b1;
        step();

        // 1: single partial set of 5, stale done_fe_i during the start cycle.
        set_delays(3);
        run_frame(1, 5, 4, 14, 1, 0);
        check("t1_n_start", 32'(n_st), 32'd1);
        check("t1_start_cyc", 32'(st_cyc[0]), 32'd1);
        check("t1_start_val", 32'(st_val[0]), 32'h00001F);
        check("t1_n_done_fe", 32'(n_df), 32'd1);
        check("t1_done_fe_cyc", 32'(df_cyc[0]), 32'd5);
        check("t1_n_frame_done", 32'(n_fd), 32'd1);
        check("t1_frame_done_cyc", 32'(fd_cyc), 32'd10);
        check("t1_busy_mid", 32'(busy_at[5]), 32'd1);
        check("t1_busy_after", 32'(busy_at[11]), 32'd0);

        // 2: three full sets, registration 10 cycles behind each done_fe.
        set_delays(1);
        run_frame(3, 0, 10, 40, 0, 0);
        check("t2_n_start", 32'(n_st), 32'd3);
        check("t2_start_cyc1", 32'(st_cyc[1]), 32'd4);
        check("t2_start_cyc2", 32'(st_cyc[2]), 32'd14);
        check("t2_start_val2", 32'(st_val[2]), 32'hFFFFFF);
        check("t2_cnt0", 32'(st_cnt[0]), 32'd0);
        check("t2_cnt1", 32'(st_cnt[1]), 32'd1);
        check("t2_cnt2", 32'(st_cnt[2]), 32'd2);
        check("t2_n_done_fe", 32'(n_df), 32'd3);
        check("t2_done_fe_cyc0", 32'(df_cyc[0]), 32'd3);
        check("t2_done_fe_cyc1", 32'(df_cyc[1]), 32'd13);
        check("t2_done_fe_cyc2", 32'(df_cyc[2]), 32'd23);
        check("t2_n_frame_done", 32'(n_fd), 32'd1);
        check("t2_frame_done_cyc", 32'(fd_cyc), 32'd34);
        check("t2_busy_after", 32'(busy_at[35]), 32'd0);

        // 3: staggered PE dones, last set of 2 with inactive PEs pulsing early.
        for (int i = 0; i < int'(PE_NUM); i++) pe_delay[i] = 2 + (i % 5);
        pe_delay[0]  = 1;
        pe_delay[23] = 7;
        run_frame(2, 2, 1, 20, 0, 0);
        check("t3_n_start", 32'(n_st), 32'd2);
        check("t3_start_val0", 32'(st_val[0]), 32'hFFFFFF);
        check("t3_start_cyc1", 32'(st_cyc[1]), 32'd10);
        check("t3_start_val1", 32'(st_val[1]), 32'h000003);
        check("t3_done_fe_cyc0", 32'(df_cyc[0]), 32'd9);
        check("t3_done_fe_cyc1", 32'(df_cyc[1]), 32'd14);
        check("t3_n_done_fe", 32'(n_df), 32'd2);
        check("t3_frame_done_cyc", 32'(fd_cyc), 32'd16);

        // 4: empty frame.
        set_delays(1);
        run_frame(0, 0, 1, 5, 0, 0);
        check("t4_n_start", 32'(n_st), 32'd0);
        check("t4_n_done_fe", 32'(n_df), 32'd0);
        check("t4_n_frame_done", 32'(n_fd), 32'd1);
        check("t4_frame_done_cyc", 32'(fd_cyc), 32'd1);
        check("t4_busy_after", 32'(busy_at[2]), 32'd0);

        // 5: reset while set 1 waits in hold with registration pending.
        run_frame(2, 0, 100, 12, 0, 0);
        check("t5_pre_n_done_fe", 32'(n_df), 32'd1);
        check("t5_pre_busy", 32'(busy_at[12]), 32'd1);
        reset_N = 1'b0;
        step();
        check_outputs_zero("t5_rst");
        reset_N = 1'b1;
        step();
        run_frame(2, 0, 2, 12, 0, 0);
        check("t5_done_fe_cyc0", 32'(df_cyc[0]), 32'd3);
        check("t5_done_fe_cyc1", 32'(df_cyc[1]), 32'd6);
        check("t5_frame_done_cyc", 32'(fd_cyc), 32'd9);

        // 6: spurious done_registration in idle, start_fe re-pulsed mid-frame.
        done_registration = 1'b1;
        #1;
        check("t6_idle_busy", 32'(busy), 32'd0);
        step();
        done_registration = 1'b0;
        run_frame(2, 3, 2, 12, 0, 2);
        check("t6_n_start", 32'(n_st), 32'd2);
        check("t6_start_val1", 32'(st_val[1]), 32'h000007);
        check("t6_cnt1", 32'(st_cnt[1]), 32'd1);
        check("t6_done_fe_cyc0", 32'(df_cyc[0]), 32'd3);
        check("t6_done_fe_cyc1", 32'(df_cyc[1]), 32'd6);
        check("t6_n_done_fe", 32'(n_df), 32'd2);
        check("t6_n_frame_done", 32'(n_fd), 32'd1);
        check("t6_frame_done_cyc", 32'(fd_cyc), 32'd9);
        check("t6_busy_after", 32'(busy_at[10]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
